// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC snapshot block: register map and bus FSM states.
package rtc_pkg;

    localparam logic [2:0] ADDR_CLOCK     = 3'd0;
    localparam logic [2:0] ADDR_TIMER     = 3'd1;
    localparam logic [2:0] ADDR_STOPWATCH = 3'd2;
    localparam logic [2:0] ADDR_ALARM     = 3'd3;
    localparam logic [2:0] ADDR_SPEED     = 3'd4;
    localparam logic [2:0] ADDR_HACKTIME  = 3'd5;
    localparam logic [2:0] ADDR_HACKHI    = 3'd6;
    localparam logic [2:0] ADDR_HACKLO    = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ACK  = 2'd2
    } state_e;

endpackage

// File: rtl/rtc_wb_watchdog.sv
// Bus watchdog: counts cycles spent waiting for an ack and flags expiry once the
// (2^LGTIMEOUT-1)-th waiting cycle passes without the counter being cleared.
module rtc_wb_watchdog #(
    parameter int LGTIMEOUT = 4
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam logic [LGTIMEOUT-1:0] LAST = {{(LGTIMEOUT-1){1'b1}}, 1'b0};

    logic [LGTIMEOUT-1:0] cnt_q;

    // Expiry fires on the cycle whose count would reach the limit; clear wins.
    assign o_expired = i_enable && !i_clear && (cnt_q == LAST);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt_q <= '0;
        end else if (i_clear) begin
            cnt_q <= '0;
        end else if (i_enable && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/rtc_snapshot.sv
// Wishbone initiator that serves single register writes and reads an atomic
// four-register RTC snapshot (clock, timer, stopwatch, alarm) on request.
module rtc_snapshot
    import rtc_pkg::*;
#(
    parameter int LGTIMEOUT = 4
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_trigger,
    input  logic        i_wr_req,
    input  logic [2:0]  i_wr_addr,
    input  logic [31:0] i_wr_data,
    input  logic [3:0]  i_wr_sel,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic        o_wb_we,
    output logic [2:0]  o_wb_addr,
    output logic [31:0] o_wb_data,
    output logic [3:0]  o_wb_sel,
    input  logic        i_wb_stall,
    input  logic        i_wb_ack,
    input  logic        i_wb_err,
    input  logic [31:0] i_wb_data,
    output logic [31:0] o_clock,
    output logic [31:0] o_timer,
    output logic [31:0] o_stopwatch,
    output logic [31:0] o_alarm,
    output logic        o_snap_valid,
    output logic        o_wr_done,
    output logic        o_err,
    output logic        o_busy
);

    state_e      state_q;
    logic [1:0]  idx_q;
    logic        pend_q, cyc_q, stb_q, we_q;
    logic [2:0]  addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  sel_q;
    logic [31:0] sh_q [3];
    logic [31:0] clock_q, timer_q, stopwatch_q, alarm_q;
    logic        snap_q, done_q, err_q;

    logic accept_d, ack_d, expired_d, abort_d;

    assign accept_d = (state_q == REQ) && stb_q && !i_wb_stall;
    assign ack_d    = (state_q == ACK) && i_wb_ack;
    assign abort_d  = (state_q != IDLE) && (i_wb_err || expired_d);

    rtc_wb_watchdog #(.LGTIMEOUT(LGTIMEOUT)) u_watchdog (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_clear   (accept_d || ack_d),
        .i_enable  (state_q == ACK),
        .o_expired (expired_d)
    );

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            pend_q      <= 1'b0;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            sel_q       <= '0;
            for (int i = 0; i < 3; i++) sh_q[i] <= '0;
            clock_q     <= '0;
            timer_q     <= '0;
            stopwatch_q <= '0;
            alarm_q     <= '0;
            snap_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            snap_q <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (i_trigger && (state_q != IDLE)) pend_q <= 1'b1;

            if (abort_d) begin
                state_q <= IDLE;
                idx_q   <= '0;
                cyc_q   <= 1'b0;
                stb_q   <= 1'b0;
                we_q    <= 1'b0;
                err_q   <= 1'b0 | 1'b1;
            end else begin
                case (state_q)
                    IDLE: begin
                        // A held-over trigger outranks a fresh write; a fresh write outranks a fresh trigger.
                        if (pend_q || (i_trigger && !i_wr_req)) begin
                            state_q <= REQ;
                            idx_q   <= '0;
                            pend_q  <= 1'b0;
                            cyc_q   <= 1'b1;
                            stb_q   <= 1'b1;
                            we_q    <= 1'b0;
                            addr_q  <= ADDR_CLOCK;
                            wdata_q <= '0;
                            sel_q   <= 4'hF;
                        end else if (i_wr_req) begin
                            state_q <= REQ;
                            pend_q  <= i_trigger;
                            cyc_q   <= 1'b1;
                            stb_q   <= 1'b1;
                            we_q    <= 1'b1;
                            addr_q  <= i_wr_addr;
                            wdata_q <= i_wr_data;
                            sel_q   <= i_wr_sel;
                        end
                    end
                    REQ: begin
                        if (accept_d) begin
                            stb_q   <= 1'b0;
                            state_q <= ACK;
                        end
                    end
                    ACK: begin
                        if (ack_d) begin
                            if (we_q) begin
                                state_q <= IDLE;
                                cyc_q   <= 1'b0;
                                we_q    <= 1'b0;
                                done_q  <= 1'b1;
                            end else if (idx_q == ADDR_ALARM[1:0]) begin
                                // Publish all four registers together with the valid strobe.
                                clock_q     <= sh_q[0];
                                timer_q     <= sh_q[1];
                                stopwatch_q <= sh_q[2];
                                alarm_q     <= i_wb_data;
                                snap_q      <= 1'b1;
                                state_q     <= IDLE;
                                cyc_q       <= 1'b0;
                                idx_q       <= '0;
                            end else begin
                                sh_q[idx_q] <= i_wb_data;
                                idx_q       <= idx_q + 2'd1;
                                addr_q      <= {1'b0, idx_q + 2'd1};
                                stb_q       <= 1'b1;
                                state_q     <= REQ;
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign o_wb_cyc     = cyc_q;
    assign o_wb_stb     = stb_q;
    assign o_wb_we      = we_q;
    assign o_wb_addr    = addr_q;
    assign o_wb_data    = wdata_q;
    assign o_wb_sel     = sel_q;
    assign o_clock      = clock_q;
    assign o_timer      = timer_q;
    assign o_stopwatch  = stopwatch_q;
    assign o_alarm      = alarm_q;
    assign o_snap_valid = snap_q;
    assign o_wr_done    = done_q;
    assign o_err        = err_q;
    assign o_busy       = cyc_q || (state_q != IDLE);

endmodule
